// File: rtl/dp_vec_mem_if.sv
// Bus bundle for dp_vec_mem: single-cycle write port, burst read request and
// valid/ready stream, plus status flags.
interface dp_vec_mem_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LEN_WIDTH  = 7
);
    logic                  init_busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_start;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [LEN_WIDTH-1:0]  rd_len;
    logic                  rd_busy;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  rd_ready;
    logic                  err_range;

    modport master (
        input  init_busy, rd_busy, rd_data, rd_valid, rd_last, err_range,
        output wr_en, wr_addr, wr_data, rd_start, rd_base, rd_len, rd_ready
    );

    modport slave (
        output init_busy, rd_busy, rd_data, rd_valid, rd_last, err_range,
        input  wr_en, wr_addr, wr_data, rd_start, rd_base, rd_len, rd_ready
    );
endinterface

// File: rtl/dp_vec_mem.sv
// Operand store for the dot-product datapath: write port plus burst read streamer,
// cleared by an init sweep after reset. Optional macro DP_MEM_BYPASS_EN selects write-first RDW.
module dp_vec_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned MEM_SIZE   = 64,
    parameter int unsigned LEN_WIDTH  = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    dp_vec_mem_if.slave bus
);
    localparam int unsigned SUM_WIDTH = LEN_WIDTH + 1;
    localparam int unsigned CMP_WIDTH = ADDR_WIDTH + 1;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]  left_q, left_d;
    logic                  wait_q, wait_d;
    logic                  init_busy_q, init_busy_d;
    logic                  rd_busy_q, rd_busy_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  err_q, err_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  wr_in_range;
    logic                  wr_ok;
    logic                  wr_bad;
    logic                  rd_bad;
    logic                  fetch;
    logic                  beat_done;
    logic [DATA_WIDTH-1:0] rd_word;

    // Request qualification; burst end is computed one bit wider so base+len cannot wrap.
    always_comb begin
        wr_in_range = CMP_WIDTH'(bus.wr_addr) < CMP_WIDTH'(MEM_SIZE);
        wr_ok       = bus.wr_en && (state_q != ST_INIT) && wr_in_range;
        wr_bad      = bus.wr_en && (state_q != ST_INIT) && !wr_in_range;
        rd_bad      = bus.rd_start && (state_q == ST_IDLE) && (bus.rd_len != '0) &&
                      ((SUM_WIDTH'(bus.rd_base) + SUM_WIDTH'(bus.rd_len)) > SUM_WIDTH'(MEM_SIZE));
        fetch       = (state_q == ST_STREAM) && !wait_q && (left_q != '0) &&
                      (!rd_valid_q || bus.rd_ready);
        beat_done   = rd_valid_q && bus.rd_ready && rd_last_q;
`ifdef DP_MEM_BYPASS_EN
        rd_word     = (wr_ok && (bus.wr_addr == rd_addr_q)) ? bus.wr_data : mem_q[rd_addr_q];
`else
        rd_word     = mem_q[rd_addr_q];
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_addr_d   = rd_addr_q;
        left_d      = left_q;
        wait_d      = 1'b0;
        init_busy_d = init_busy_q;
        rd_busy_d   = rd_busy_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        rd_data_d   = rd_data_q;
        err_d       = wr_bad || rd_bad;
        mem_we      = wr_ok;
        mem_addr    = bus.wr_addr;
        mem_wdata   = bus.wr_data;

        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_addr   = init_cnt_q;
                mem_wdata  = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == ADDR_WIDTH'(MEM_SIZE - 1)) begin
                    init_cnt_d  = '0;
                    init_busy_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.rd_start && (bus.rd_len != '0) && !rd_bad) begin
                    rd_addr_d = bus.rd_base;
                    left_d    = bus.rd_len;
                    wait_d    = 1'b1;
                    rd_busy_d = 1'b1;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (fetch) begin
                    rd_data_d  = rd_word;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (left_q == LEN_WIDTH'(1));
                    rd_addr_d  = rd_addr_q + 1'b1;
                    left_d     = left_q - 1'b1;
                end else if (rd_valid_q && bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                end
                if (beat_done) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    rd_busy_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rd_addr_q   <= '0;
            left_q      <= '0;
            wait_q      <= 1'b0;
            init_busy_q <= 1'b1;
            rd_busy_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rd_addr_q   <= rd_addr_d;
            left_q      <= left_d;
            wait_q      <= wait_d;
            init_busy_q <= init_busy_d;
            rd_busy_q   <= rd_busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
        end
    end

    // Storage array has no reset; the init sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign bus.init_busy = init_busy_q;
    assign bus.rd_busy   = rd_busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.err_range = err_q;

endmodule

// File: tb/tb_dp_vec_mem.sv
// Self-checking bench for dp_vec_mem: directed steps plus random writes/bursts
// compared against an array model of the store.
module tb_dp_vec_mem;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] model [64];

    dp_vec_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .LEN_WIDTH(7)) b1 ();
    dp_vec_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .LEN_WIDTH(7)) b2 ();

    dp_vec_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .MEM_SIZE(64), .LEN_WIDTH(7)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    dp_vec_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .MEM_SIZE(48), .LEN_WIDTH(7)) dut48 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Counts edges until each init_busy drops; illegal traffic is held during the first 10.
    task automatic wait_init(input int exp1, input int exp2);
        int   k1;
        int   k2;
        logic err_seen;
        k1 = 0; k2 = 0; err_seen = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin
                b1.wr_en = 1'b0;
                b1.rd_start = 1'b0;
            end
            err_seen = err_seen | b1.err_range;
            if (k1 == 0 && !b1.init_busy) k1 = c;
            if (k2 == 0 && !b2.init_busy) k2 = c;
            if (k1 != 0 && k2 != 0) break;
        end
        check("init_len", 32'(k1), 32'(exp1));
        check("init_len48", 32'(k2), 32'(exp2));
        check("init_no_err", 32'(err_seen), 32'd0);
    endtask

    task automatic wr1(input int a, input logic [7:0] d);
        @(negedge clk);
        b1.wr_en = 1'b1; b1.wr_addr = 6'(a); b1.wr_data = d;
        @(negedge clk);
        b1.wr_en = 1'b0;
        check("wr_err", 32'(b1.err_range), 32'd0);
        model[a] = d;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready + stray rd_start
    task automatic burst(input int base, input int len, input int mode);
        int         idx;
        int         cyc;
        logic       rdy;
        logic       stalled;
        logic [7:0] held_data;
        logic       held_last;
        @(negedge clk);
        b1.rd_start = 1'b1; b1.rd_base = 6'(base); b1.rd_len = 7'(len); b1.rd_ready = 1'b0;
        @(negedge clk);
        b1.rd_start = 1'b0;
        check("busy_after_start", 32'(b1.rd_busy), 32'd1);
        check("valid_edge1", 32'(b1.rd_valid), 32'd0);
        @(negedge clk);
        check("valid_edge2", 32'(b1.rd_valid), 32'd0);
        idx = 0; cyc = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
        while (idx < len && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("first_valid", 32'(b1.rd_valid), 32'd1);
            check("stream_err", 32'(b1.err_range), 32'd0);
            if (stalled) begin
                check("hold_data", 32'(b1.rd_data), 32'(held_data));
                check("hold_last", 32'(b1.rd_last), 32'(held_last));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            b1.rd_ready = rdy;
            if (mode == 2) begin
                b1.rd_start = 1'($urandom_range(0, 1));
                b1.rd_base  = 6'd60;
                b1.rd_len   = 7'd5;
            end
            stalled = 1'b0;
            if (b1.rd_valid) begin
                if (rdy) begin
                    check("beat_data", 32'(b1.rd_data), 32'(model[base + idx]));
                    check("beat_last", 32'(b1.rd_last), 32'(idx == len - 1));
                    idx++;
                end else begin
                    stalled   = 1'b1;
                    held_data = b1.rd_data;
                    held_last = b1.rd_last;
                end
            end
        end
        check("burst_complete", 32'(idx), 32'(len));
        @(negedge clk);
        b1.rd_start = 1'b0; b1.rd_ready = 1'b0;
        check("end_busy", 32'(b1.rd_busy), 32'd0);
        check("end_valid", 32'(b1.rd_valid), 32'd0);
        check("end_last", 32'(b1.rd_last), 32'd0);
    endtask

    task automatic bad_burst(input int base, input int len);
        @(negedge clk);
        b1.rd_start = 1'b1; b1.rd_base = 6'(base); b1.rd_len = 7'(len);
        @(negedge clk);
        b1.rd_start = 1'b0;
        check("bad_err", 32'(b1.err_range), 32'd1);
        check("bad_busy", 32'(b1.rd_busy), 32'd0);
        @(negedge clk);
        check("bad_err_pulse", 32'(b1.err_range), 32'd0);
        check("bad_busy2", 32'(b1.rd_busy), 32'd0);
    endtask

    initial begin
        int         acc;
        int         base;
        int         len;
        logic [7:0] exp_rdw;
        n_checks = 0; n_fail = 0;
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_data = '0;
        b1.rd_start = 1'b0; b1.rd_base = '0; b1.rd_len = '0; b1.rd_ready = 1'b0;
        b2.wr_en = 1'b0; b2.wr_addr = '0; b2.wr_data = '0;
        b2.rd_start = 1'b0; b2.rd_base = '0; b2.rd_len = '0; b2.rd_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_init_busy", 32'(b1.init_busy), 32'd1);
        check("rst_rd_busy", 32'(b1.rd_busy), 32'd0);
        check("rst_rd_valid", 32'(b1.rd_valid), 32'd0);
        check("rst_rd_last", 32'(b1.rd_last), 32'd0);
        check("rst_err", 32'(b1.err_range), 32'd0);
        check("rst_rd_data", 32'(b1.rd_data), 32'd0);

        // Release with illegal-during-init traffic applied
        rst_n = 1'b1;
        b1.wr_en = 1'b1; b1.wr_addr = 6'd3; b1.wr_data = 8'h77;
        b1.rd_start = 1'b1; b1.rd_base = 6'd60; b1.rd_len = 7'd5;
        wait_init(64, 48);
        burst(0, 64, 0);

        for (int i = 0; i < 8; i++) wr1(i, 8'(i + 1));
        burst(2, 4, 0);
        burst(2, 4, 1);

        bad_burst(60, 5);
        // Zero-length request is a silent no-op
        @(negedge clk);
        b1.rd_start = 1'b1; b1.rd_base = 6'd10; b1.rd_len = 7'd0;
        @(negedge clk);
        b1.rd_start = 1'b0;
        check("len0_err", 32'(b1.err_range), 32'd0);
        check("len0_busy", 32'(b1.rd_busy), 32'd0);

        wr1(63, 8'hC3);
        burst(63, 1, 0);
        burst(60, 4, 2);

        for (int it = 0; it < 16; it++) begin
            for (int j = 0; j < int'($urandom_range(1, 4)); j++)
                wr1(int'($urandom_range(0, 63)), 8'($urandom));
            base = int'($urandom_range(0, 63));
            len  = int'($urandom_range(1, 64 - base));
            burst(base, len, 2);
            if (it % 4 == 0) begin
                base = int'($urandom_range(1, 63));
                bad_burst(base, int'($urandom_range(65 - base, 127)));
            end
        end

        // Read-during-write on the fetch cycle of a one-word burst at address 5
        wr1(5, 8'hAA);
        @(negedge clk);
        b1.rd_start = 1'b1; b1.rd_base = 6'd5; b1.rd_len = 7'd1;
        @(negedge clk);
        b1.rd_start = 1'b0;
        @(negedge clk);
        b1.wr_en = 1'b1; b1.wr_addr = 6'd5; b1.wr_data = 8'h55; b1.rd_ready = 1'b1;
        @(negedge clk);
        b1.wr_en = 1'b0;
`ifdef DP_MEM_BYPASS_EN
        exp_rdw = 8'h55;
`else
        exp_rdw = 8'hAA;
`endif
        check("rdw_valid", 32'(b1.rd_valid), 32'd1);
        check("rdw_data", 32'(b1.rd_data), 32'(exp_rdw));
        check("rdw_last", 32'(b1.rd_last), 32'd1);
        @(negedge clk);
        b1.rd_ready = 1'b0;
        check("rdw_done", 32'(b1.rd_busy), 32'd0);
        model[5] = 8'h55;
        burst(5, 1, 0);

        // Reset while beat 3 of an 8-beat burst is on the bus
        for (int i = 0; i < 8; i++) wr1(i, 8'($urandom) | 8'h01);
        @(negedge clk);
        b1.rd_start = 1'b1; b1.rd_base = 6'd0; b1.rd_len = 7'd8; b1.rd_ready = 1'b1;
        @(negedge clk);
        b1.rd_start = 1'b0;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (b1.rd_valid && acc == 2) break;
            if (b1.rd_valid) acc++;
        end
        check("pre_reset_beats", 32'(acc), 32'd2);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(b1.rd_valid), 32'd0);
        check("abort_busy", 32'(b1.rd_busy), 32'd0);
        check("abort_last", 32'(b1.rd_last), 32'd0);
        check("abort_data", 32'(b1.rd_data), 32'd0);
        check("abort_init_busy", 32'(b1.init_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; b1.rd_ready = 1'b0;
        wait_init(64, 48);
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        burst(0, 8, 0);

        // 48-word instance: out-of-range write dropped, range check uses MEM_SIZE
        @(negedge clk);
        b2.wr_en = 1'b1; b2.wr_addr = 6'd2; b2.wr_data = 8'h5A;
        @(negedge clk);
        b2.wr_addr = 6'd50; b2.wr_data = 8'hEE;
        check("m48_wr_ok", 32'(b2.err_range), 32'd0);
        @(negedge clk);
        b2.wr_en = 1'b0;
        check("m48_wr_err", 32'(b2.err_range), 32'd1);
        @(negedge clk);
        check("m48_wr_err_pulse", 32'(b2.err_range), 32'd0);
        b2.rd_start = 1'b1; b2.rd_base = 6'd40; b2.rd_len = 7'd9;
        @(negedge clk);
        b2.rd_start = 1'b0;
        check("m48_bad_burst", 32'(b2.err_range), 32'd1);
        check("m48_bad_busy", 32'(b2.rd_busy), 32'd0);
        b2.rd_start = 1'b1; b2.rd_base = 6'd2; b2.rd_len = 7'd1; b2.rd_ready = 1'b1;
        @(negedge clk);
        b2.rd_start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b2.rd_valid) break;
        end
        check("m48_rd_valid", 32'(b2.rd_valid), 32'd1);
        check("m48_rd_data", 32'(b2.rd_data), 32'h5A);
        check("m48_rd_last", 32'(b2.rd_last), 32'd1);
        @(negedge clk);
        b2.rd_ready = 1'b0;
        check("m48_done", 32'(b2.rd_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
